// File: rtl/imem_pkg.sv
// Shared types and address helpers for the programmable instruction memory.
// Address helpers work on a 64-bit zero-extended PC so no upper bits are dropped.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_e;

    localparam logic [31:0] DEFAULT_INST = 32'h0000_0000;
    localparam int unsigned PC_EXT_W     = 64;

    // Word index of a byte address; callers truncate to their own address width.
    function automatic logic [PC_EXT_W-1:0] idx_of(input logic [PC_EXT_W-1:0] pc);
        return pc >> 2;
    endfunction

    // True only for word-aligned addresses that fall inside a memory of depth words.
    function automatic logic in_range(input logic [PC_EXT_W-1:0] pc,
                                      input int unsigned       depth);
        return (pc[1:0] == 2'b00) && ((pc >> 2) < PC_EXT_W'(depth));
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module imem_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        // Read register only updates on a real read, so stalls hold the last word.
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_inst_mem.sv
// IF-stage instruction memory with a streaming program-load port.
// Holds the load FSM, write pointer, fault/range logic and the freeze/flush output control.
module prog_inst_mem #(
    parameter int unsigned       DEPTH        = 256,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       PC_W         = 32,
    parameter logic [DATA_W-1:0] DEFAULT_INST = DATA_W'(imem_pkg::DEFAULT_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              fetch_en,
    input  logic              freeze,
    input  logic              flush,
    output logic [DATA_W-1:0] instruction,
    output logic              inst_valid,
    output logic              fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done
);
    import imem_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_e             state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic                    show_ram_q, show_ram_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;

    logic [PC_EXT_W-1:0]     pc_ext;
    logic                    fetch_ok;
    logic                    beat;
    logic                    ram_we;
    logic                    ram_re;
    logic [AW-1:0]           rd_addr;
    logic [DATA_W-1:0]       ram_rdata;

    assign pc_ext   = PC_EXT_W'(pc);
    assign fetch_ok = in_range(pc_ext, DEPTH);
    assign rd_addr  = AW'(idx_of(pc_ext));

    assign load_ready = (state_q == LOAD);
    assign beat       = load_valid & load_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        show_ram_d = show_ram_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        ram_re     = 1'b0;

        case (state_q)
            RUN: begin
                if (load_start && !flush) begin
                    state_d    = LOAD;
                    show_ram_d = 1'b0;
                    valid_d    = 1'b0;
                    fault_d    = 1'b0;
                end else if (flush) begin
                    show_ram_d = 1'b0;
                    valid_d    = 1'b0;
                    fault_d    = 1'b0;
                end else if (freeze) begin
                    show_ram_d = show_ram_q;
                end else if (fetch_en) begin
                    valid_d = 1'b1;
                    if (fetch_ok) begin
                        ram_re     = 1'b1;
                        show_ram_d = 1'b1;
                        fault_d    = 1'b0;
                    end else begin
                        show_ram_d = 1'b0;
                        fault_d    = 1'b1;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                show_ram_d = 1'b0;
                valid_d    = 1'b0;
                fault_d    = 1'b0;
                if (beat) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // A full memory ends the load instead of wrapping onto word 0.
                    if (load_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                wr_ptr_d = '0;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // A beat coinciding with reset must not land in storage.
    assign ram_we = beat & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            show_ram_q <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            show_ram_q <= show_ram_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign instruction = show_ram_q ? ram_rdata : DEFAULT_INST;
    assign inst_valid  = valid_q;
    assign fault       = fault_q;
    assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_prog_inst_mem.sv
// Scoreboard bench for prog_inst_mem: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_prog_inst_mem;

    localparam int unsigned DEPTH = 256;

    localparam logic [4:0] M_OUT = 5'b00111;
    localparam logic [4:0] M_LD  = 5'b11000;
    localparam logic [4:0] M_ALL = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        fetch_en, freeze, flush;
    logic        load_start, load_valid, load_last;
    logic [31:0] load_data;
    logic [31:0] instruction;
    logic        inst_valid, fault, load_ready, load_done;

    prog_inst_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (32),
        .PC_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .freeze      (freeze),
        .flush       (flush),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .fault       (fault),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  mask;
        logic [31:0] inst;
        logic        valid;
        logic        flt;
        logic        ready;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    task automatic expect_at(input int dly, input string nm, input logic [4:0] mask,
                             input logic [31:0] inst, input logic v, input logic f,
                             input logic r, input logic d);
        exp_t e;
        int   pos;
        e.cyc = cyc + dly; e.name = nm; e.mask = mask; e.inst = inst;
        e.valid = v; e.flt = f; e.ready = r; e.done = d;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
        sb.insert(pos, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (load_done === 1'b1) done_cnt++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                if (e.mask[0]) chk({e.name, " instruction"}, instruction, e.inst);
                if (e.mask[1]) chk({e.name, " inst_valid"}, {31'b0, inst_valid}, {31'b0, e.valid});
                if (e.mask[2]) chk({e.name, " fault"}, {31'b0, fault}, {31'b0, e.flt});
                if (e.mask[3]) chk({e.name, " load_ready"}, {31'b0, load_ready}, {31'b0, e.ready});
                if (e.mask[4]) chk({e.name, " load_done"}, {31'b0, load_done}, {31'b0, e.done});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_en = 1'b0; freeze = 1'b0; flush = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w, input logic f, input string nm);
        fetch_en = 1'b1; pc = a; freeze = 1'b0; flush = 1'b0;
        expect_at(1, nm, M_OUT, w, 1'b1, f, 1'b0, 1'b0);
        step();
        fetch_en = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input bit gaps, input string nm);
        logic [31:0] w [4];
        int          d0;
        w  = '{w0, w1, w2, w3};
        d0 = done_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        expect_at(0, {nm, " enter"}, 5'b11011, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (gaps && (i % 2 == 1)) begin
                load_valid = 1'b0; load_data = 32'hDEAD_BEEF; load_last = 1'b1;
                step();
                expect_at(0, {nm, " gap"}, M_LD, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            load_valid = 1'b1; load_data = w[i]; load_last = (i == 3);
            step();
        end
        idle();
        expect_at(0, {nm, " done"}, M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        expect_at(0, {nm, " back to run"}, M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({nm, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        idle();
        rst = 1'b1;
        step();
        expect_at(0, "reset", M_ALL, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // Basic program load and fetch-back
        do_load(32'hE3A00A01, 32'hE3A01015, 32'hE3A02018, 32'hEAFFFFFF, 1'b0, "load");
        fetch(32'd0,  32'hE3A00A01, 1'b0, "fetch pc0");
        fetch(32'd4,  32'hE3A01015, 1'b0, "fetch pc4");
        fetch(32'd8,  32'hE3A02018, 1'b0, "fetch pc8");
        fetch(32'd12, 32'hEAFFFFFF, 1'b0, "fetch pc12");
        expect_at(1, "no fetch holds", M_OUT, 32'hEAFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Freeze holds, release fetches the new PC
        fetch(32'd4, 32'hE3A01015, 1'b0, "freeze setup");
        for (int k = 0; k < 3; k++) begin
            freeze = 1'b1; fetch_en = 1'b1; pc = 32'd8;
            expect_at(1, "freeze hold", M_OUT, 32'hE3A01015, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        fetch(32'd8, 32'hE3A02018, 1'b0, "freeze release");

        // Flush wins over freeze; a following freeze holds the bubble
        freeze = 1'b1; flush = 1'b1; fetch_en = 1'b1; pc = 32'd12;
        expect_at(1, "flush beats freeze", M_OUT, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        expect_at(1, "freeze after flush", M_OUT, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();

        // load_start is ignored while flushing
        load_start = 1'b1; flush = 1'b1;
        step();
        idle();
        expect_at(0, "load_start under flush", M_ALL, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_at(0, "still run after flush", M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overflow: DEPTH+3 beats, never load_last
        d0 = done_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            load_valid = 1'b1; load_data = 32'hA500_0000 + 32'(i); load_last = 1'b0;
            step();
            if (i == int'(DEPTH) - 2)
                expect_at(0, "overflow before final", M_LD, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == int'(DEPTH) - 1)
                expect_at(0, "overflow done", M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i >= int'(DEPTH))
                expect_at(0, "overflow ready low", M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        step();
        chk("overflow done pulses", 32'(done_cnt - d0), 32'd1);

        fetch(32'd0,          32'hA500_0000, 1'b0, "overflow mem0 kept");
        fetch(32'd1020,       32'hA500_00FF, 1'b0, "pc 1020 in range");
        fetch(32'd1024,       32'h0,         1'b1, "pc 1024 fault");
        fetch(32'd6,          32'h0,         1'b1, "pc 6 misaligned");
        fetch(32'h0000_1000,  32'h0,         1'b1, "pc 4096 fault");
        fetch(32'hFFFF_FFFC,  32'h0,         1'b1, "pc top fault");
        fetch(32'd8,          32'hA500_0002, 1'b0, "fetch after fault");

        // Load with valid gaps (load_last raised during gaps)
        do_load(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 1'b1, "gap load");
        fetch(32'd0,  32'hB000_0000, 1'b0, "gap word0");
        fetch(32'd4,  32'hB000_0001, 1'b0, "gap word1");
        fetch(32'd8,  32'hB000_0002, 1'b0, "gap word2");
        fetch(32'd12, 32'hB000_0003, 1'b0, "gap word3");
        fetch(32'd16, 32'hA500_0004, 1'b0, "gap no spurious write");

        // Reset mid-load after two beats, third beat coincides with reset
        d0 = done_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'hC000_0000;
        step();
        load_data = 32'hC000_0001;
        step();
        rst = 1'b1; load_data = 32'hC000_0002;
        step();
        expect_at(0, "reset mid-load", M_ALL, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle();
        step();
        expect_at(0, "run after reset", M_LD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("reset mid-load no done", 32'(done_cnt - d0), 32'd0);
        fetch(32'd0, 32'hC000_0000, 1'b0, "partial word0");
        fetch(32'd4, 32'hC000_0001, 1'b0, "partial word1");
        fetch(32'd8, 32'hB000_0002, 1'b0, "word2 untouched");

        do_load(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 1'b0, "reload");
        fetch(32'd0,  32'hD000_0000, 1'b0, "reload starts at word0");
        fetch(32'd12, 32'hD000_0003, 1'b0, "reload word3");
        fetch(32'd16, 32'hA500_0004, 1'b0, "reload word4 untouched");
        idle();

        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
